// File: rtl/reduce_hybrid_param.sv
// Hybrid reducer: a parallel operator tree folds LANES words per beat, then an accumulator folds BEATS beats per frame.
// Optional macro REDUCE_TREE_PIPE_EN adds a register stage between the tree and the accumulator.
module reduce_hybrid_param #(
    parameter int WIDTH = 16,
    parameter int LANES = 2,
    parameter int BEATS = 4
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    input  logic [LANES*WIDTH-1:0]   I,
    input  logic                     WE,
    input  logic [1:0]               OP,
    input  logic                     CLR,
    output logic [WIDTH-1:0]         O,
    output logic                     V,
    output logic                     BUSY
);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_MAX = 2'd1;
    localparam logic [1:0] OP_MIN = 2'd2;
    localparam logic [1:0] OP_XOR = 2'd3;

    localparam int P  = 1 << $clog2(LANES);
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LASTCNT = CW'(BEATS - 1);

    function automatic logic [WIDTH-1:0] combine(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [1:0]       op);
        logic [WIDTH-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_MAX:  r = (a > b) ? a : b;
            OP_MIN:  r = (a < b) ? a : b;
            OP_XOR:  r = a ^ b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] identity(input logic [1:0] op);
        return (op == OP_MIN) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    endfunction

    // Unused leaves of the power-of-2 tree hold the operator identity so padding never changes the result.
    function automatic logic [WIDTH-1:0] treeReduce(input logic [LANES*WIDTH-1:0] data,
                                                    input logic [1:0]             op);
        logic [WIDTH-1:0] node [P];
        for (int k = 0; k < P; k++) begin
            if (k < LANES) node[k] = data[k*WIDTH +: WIDTH];
            else           node[k] = identity(op);
        end
        for (int span = P; span > 1; span = span / 2) begin
            for (int j = 0; j < span / 2; j++) begin
                node[j] = combine(node[2*j], node[2*j+1], op);
            end
        end
        return node[0];
    endfunction

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             v_q, v_d;

    logic             beatFirst, beatLast, accept;
    logic [1:0]       treeOp;
    logic [WIDTH-1:0] beatVal;

    assign beatFirst = (cnt_q == '0);
    assign beatLast  = (cnt_q == LASTCNT);
    assign accept    = WE && !CLR;
    assign treeOp    = beatFirst ? OP : op_q;
    assign beatVal   = treeReduce(I, treeOp);

    always_comb begin
        cnt_d = cnt_q;
        op_d  = op_q;
        if (CLR) begin
            cnt_d = '0;
        end else if (WE) begin
            if (beatFirst) op_d = OP;
            cnt_d = beatLast ? '0 : cnt_q + CW'(1);
        end
    end

    logic             stValid, stFirst, stLast;
    logic [WIDTH-1:0] stVal;
    logic [1:0]       stOp;

`ifdef REDUCE_TREE_PIPE_EN
    logic             pipeValid_q, pipeFirst_q, pipeLast_q;
    logic [WIDTH-1:0] pipeVal_q;
    logic [1:0]       pipeOp_q;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            pipeValid_q <= 1'b0;
            pipeFirst_q <= 1'b0;
            pipeLast_q  <= 1'b0;
            pipeVal_q   <= '0;
            pipeOp_q    <= OP_ADD;
        end else begin
            pipeValid_q <= accept;
            pipeFirst_q <= beatFirst;
            pipeLast_q  <= beatLast;
            pipeVal_q   <= beatVal;
            pipeOp_q    <= treeOp;
        end
    end

    assign stValid = pipeValid_q;
    assign stFirst = pipeFirst_q;
    assign stLast  = pipeLast_q;
    assign stVal   = pipeVal_q;
    assign stOp    = pipeOp_q;
`else
    assign stValid = accept;
    assign stFirst = beatFirst;
    assign stLast  = beatLast;
    assign stVal   = beatVal;
    assign stOp    = op_q;
`endif

    logic             accFire;
    logic [WIDTH-1:0] accNext;

    // CLR also suppresses whatever beat reaches the accumulator this cycle, including a pipelined one.
    assign accFire = stValid && !CLR;
    assign accNext = stFirst ? stVal : combine(acc_q, stVal, stOp);

    always_comb begin
        acc_d = acc_q;
        o_d   = o_q;
        v_d   = 1'b0;
        if (accFire) begin
            acc_d = accNext;
            if (stLast) begin
                o_d = accNext;
                v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cnt_q <= '0;
            op_q  <= OP_ADD;
            acc_q <= '0;
            o_q   <= '0;
            v_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            op_q  <= op_d;
            acc_q <= acc_d;
            o_q   <= o_d;
            v_q   <= v_d;
        end
    end

    assign O    = o_q;
    assign V    = v_q;
    assign BUSY = (cnt_q != '0);

endmodule

// File: tb/tb_reduce_hybrid_param.sv
// Directed self-checking bench for reduce_hybrid_param (default instance plus a LANES=3, BEATS=1 corner instance).
module tb_reduce_hybrid_param;

`ifdef REDUCE_TREE_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic [31:0] I = '0;
    logic        WE = 1'b0;
    logic [1:0]  OP = 2'd0;
    logic        CLR = 1'b0;
    logic [15:0] O;
    logic        V;
    logic        BUSY;

    logic [47:0] cI = '0;
    logic        cWE = 1'b0;
    logic [1:0]  cOP = 2'd3;
    logic        cCLR = 1'b0;
    logic [15:0] cO;
    logic        cV;
    logic        cBUSY;

    int checks = 0;
    int errors = 0;
    int stepCount, vCount, vStep;
    logic [15:0] capO [4];

    always #5 CLK = ~CLK;

    reduce_hybrid_param #(.WIDTH(16), .LANES(2), .BEATS(4)) dut (
        .CLK(CLK), .RESETN(RESETN), .I(I), .WE(WE), .OP(OP), .CLR(CLR),
        .O(O), .V(V), .BUSY(BUSY)
    );

    reduce_hybrid_param #(.WIDTH(16), .LANES(3), .BEATS(1)) dutCorner (
        .CLK(CLK), .RESETN(RESETN), .I(cI), .WE(cWE), .OP(cOP), .CLR(cCLR),
        .O(cO), .V(cV), .BUSY(cBUSY)
    );

    task automatic clearStats();
        stepCount = 0;
        vCount    = 0;
        vStep     = -1;
        for (int k = 0; k < 4; k++) capO[k] = '0;
    endtask

    // Drive one cycle from a negedge and sample outputs at the following negedge.
    task automatic doStep(input logic [31:0] data, input logic we, input logic [1:0] op, input logic clr);
        I   = data;
        WE  = we;
        OP  = op;
        CLR = clr;
        @(negedge CLK);
        stepCount++;
        if (V) begin
            if (vCount < 4) capO[vCount] = O;
            vCount++;
            vStep = stepCount;
        end
    endtask

    task automatic drain();
        doStep(32'hDEAD_BEEF, 1'b0, 2'd0, 1'b0);
        doStep(32'hDEAD_BEEF, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic test_reset();
        checks++; if (O !== 16'h0)  begin errors++; $display("[TB] FAIL reset_O: got %0h expected 0", O); end
        checks++; if (V !== 1'b0)   begin errors++; $display("[TB] FAIL reset_V: got %0b expected 0", V); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL reset_BUSY: got %0b expected 0", BUSY); end
    endtask

    task automatic test_add();
        logic [31:0] beats [4];
        beats = '{ {16'd2, 16'd1}, {16'd4, 16'd3}, {16'hFFFF, 16'd1}, {16'd10, 16'd0} };
        clearStats();
        for (int k = 0; k < 4; k++) begin
            doStep(beats[k], 1'b1, 2'd0, 1'b0);
            checks++;
            if (BUSY !== (k < 3)) begin
                errors++; $display("[TB] FAIL add_busy[%0d]: got %0b expected %0b", k, BUSY, (k < 3));
            end
        end
        drain();
        checks++; if (vCount != 1) begin errors++; $display("[TB] FAIL add_vcount: got %0d expected 1", vCount); end
        checks++; if (capO[0] !== 16'h0014) begin errors++; $display("[TB] FAIL add_O: got %0h expected 14", capO[0]); end
        checks++; if (vStep != 3 + LAT) begin errors++; $display("[TB] FAIL add_latency: got step %0d expected %0d", vStep, 3 + LAT); end
    endtask

    task automatic test_max_min();
        logic [31:0] beats [4];
        beats = '{ {16'd9, 16'd5}, {16'd2, 16'd1}, {16'd3, 16'd7}, {16'd8, 16'd8} };
        clearStats();
        for (int k = 0; k < 4; k++) doStep(beats[k], 1'b1, 2'd1, 1'b0);
        for (int k = 0; k < 4; k++) doStep(beats[k], 1'b1, (k == 0) ? 2'd2 : 2'd3, 1'b0);
        drain();
        checks++; if (vCount != 2) begin errors++; $display("[TB] FAIL maxmin_vcount: got %0d expected 2", vCount); end
        checks++; if (capO[0] !== 16'd9) begin errors++; $display("[TB] FAIL max_O: got %0h expected 9", capO[0]); end
        checks++; if (capO[1] !== 16'd1) begin errors++; $display("[TB] FAIL min_O: got %0h expected 1", capO[1]); end
    endtask

    task automatic test_gaps();
        logic        pattern [7];
        logic [31:0] beats [7];
        pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        beats   = '{ {16'd2, 16'd1}, 32'hDEAD_BEEF, 32'h1234_5678, {16'd20, 16'd10},
                     32'hFFFF_FFFF, {16'd0, 16'd100}, {16'd1, 16'h1000} };
        clearStats();
        for (int k = 0; k < 7; k++) doStep(beats[k], pattern[k], 2'd0, 1'b0);
        drain();
        checks++; if (vCount != 1) begin errors++; $display("[TB] FAIL gaps_vcount: got %0d expected 1", vCount); end
        checks++; if (capO[0] !== 16'd4230) begin errors++; $display("[TB] FAIL gaps_O: got %0d expected 4230", capO[0]); end
        checks++; if (vStep != 6 + LAT) begin errors++; $display("[TB] FAIL gaps_latency: got step %0d expected %0d", vStep, 6 + LAT); end
    endtask

    task automatic test_clr();
        clearStats();
        doStep({16'd5, 16'd5}, 1'b1, 2'd0, 1'b0);
        doStep({16'd5, 16'd5}, 1'b1, 2'd0, 1'b0);
        doStep({16'd5, 16'd5}, 1'b1, 2'd0, 1'b1);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL clr_busy: got %0b expected 0", BUSY); end
        drain();
        checks++; if (vCount != 0) begin errors++; $display("[TB] FAIL clr_noV: got %0d expected 0", vCount); end
        checks++; if (O !== 16'd4230) begin errors++; $display("[TB] FAIL clr_Ohold: got %0d expected 4230", O); end
        for (int k = 0; k < 4; k++) doStep({16'd1, 16'd1}, 1'b1, 2'd0, 1'b0);
        drain();
        checks++; if (vCount != 1) begin errors++; $display("[TB] FAIL clr_next_vcount: got %0d expected 1", vCount); end
        checks++; if (capO[0] !== 16'd8) begin errors++; $display("[TB] FAIL clr_next_O: got %0d expected 8", capO[0]); end
    endtask

    task automatic test_reset_mid();
        doStep({16'd7, 16'd7}, 1'b1, 2'd0, 1'b0);
        doStep({16'd7, 16'd7}, 1'b1, 2'd0, 1'b0);
        WE = 1'b0;
        #2 RESETN = 1'b0;
        #1;
        checks++; if (O !== 16'h0)   begin errors++; $display("[TB] FAIL rstmid_O: got %0h expected 0", O); end
        checks++; if (V !== 1'b0)    begin errors++; $display("[TB] FAIL rstmid_V: got %0b expected 0", V); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_BUSY: got %0b expected 0", BUSY); end
        @(negedge CLK);
        RESETN = 1'b1;
        test_add();
    endtask

    task automatic test_corner();
        logic expV;
        logic [15:0] expO;
        int j;
        for (int k = 0; k < 4; k++) begin
            cOP = 2'd3;
            cWE = (k < 3);
            cI  = (k == 0) ? {16'h0, 16'h0, 16'h1} : {16'hF, 16'h5, 16'hA};
            @(negedge CLK);
            j = k - (LAT - 1);
            expV = (j >= 0) && (j < 3);
            expO = (j == 0) ? 16'h1 : 16'h0;
            checks++; if (cV !== expV) begin errors++; $display("[TB] FAIL corner_V[%0d]: got %0b expected %0b", k, cV, expV); end
            checks++; if (cO !== expO) begin errors++; $display("[TB] FAIL corner_O[%0d]: got %0h expected %0h", k, cO, expO); end
        end
        checks++; if (cBUSY !== 1'b0) begin errors++; $display("[TB] FAIL corner_BUSY: got %0b expected 0", cBUSY); end
        cWE = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        test_reset();
        RESETN = 1'b1;
        @(negedge CLK);
        test_reset();
        test_add();
        test_max_min();
        test_gaps();
        test_clr();
        test_reset_mid();
        test_corner();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
